id_ex_stage_reg: RTL
====================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage core. Consumes the hazard-control outputs (load-use stall, branch flush) and turns them into bubbles in EX.
- Registers the decoded instruction, operands and control bits from ID, and presents them to EX, the forwarding logic and the load-use detector.
- Optionally keeps hazard performance counters.

Parameters:
- XLEN, 32, datapath width for pc, rs1_data, rs2_data, imm.
- ALUCTRL_W, 4, width of the ALU control field.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- clr  in  1  asynchronous active-high reset.
- stall  in  1  load-use stall request. ID holds; EX must receive a bubble.
- flush  in  1  branch/reset flush request.
- valid_id  in  1  ID holds a real instruction.
- pc_id  in  XLEN  PC of the ID instruction.
- rs1_data_id, rs2_data_id  in  XLEN each  register-file read data.
- imm_id  in  XLEN  decoded immediate.
- rs1_addr_id, rs2_addr_id, rd_addr_id  in  5 each  register addresses.
- regwr_id, mem2reg_id, memwr_id, branch_id  in  1 each  control bits.
- aluctrl_id  in  ALUCTRL_W  ALU operation.
- valid_ex  out  1  EX holds a real instruction.
- pc_ex, rs1_data_ex, rs2_data_ex, imm_ex  out  XLEN each  registered copies.
- rs1_addr_ex, rs2_addr_ex, rd_addr_ex  out  5 each  registered copies.
- regwr_ex, mem2reg_ex, memwr_ex, branch_ex  out  1 each  registered, bubble-masked.
- aluctrl_ex  out  ALUCTRL_W  registered copy.
- bubble_ex  out  1  EX holds a bubble inserted by stall or flush this cycle.
- stall_cnt, flush_cnt, instr_cnt  out  CNT_W each  performance counters (see Optional Feature).

Behaviour:
- Reset (clr=1, asynchronous): every output is 0, including all counters. bubble_ex=1. Reset takes effect mid-operation regardless of clk.
- Latency: 1 cycle. Inputs sampled on posedge clk appear on the *_ex outputs after that edge.
- Priority at each posedge: flush > stall > normal.
- Flush: load a bubble.
  - valid_ex=0; regwr_ex, mem2reg_ex, memwr_ex, branch_ex = 0; rd_addr_ex=0; bubble_ex=1.
  - Data fields (pc, data, imm, rs addresses, aluctrl) load 0.
- Stall (no flush): load a bubble, same as flush. The ID instruction is not lost because ID/IF hold their own registers. The stall input is never used to freeze this register.
- Normal: load all fields from ID.
  - valid_ex=valid_id; bubble_ex=0.
  - Control bits and rd_addr_ex are ANDed with valid_id. An invalid ID slot never writes the register file or memory.
- rd_addr_ex=0 always implies regwr_ex is don't-care downstream. The forwarding logic ignores x0.
- Stall and flush asserted in the same cycle count as a flush only.
- Back-to-back stalls: each stalled cycle inserts one more bubble.
- Stall has no memory: the first cycle after stall deasserts loads the held ID instruction normally.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on each posedge where stall=1 and flush=0.
  - flush_cnt increments on each posedge where flush=1.
  - instr_cnt increments on each posedge that loads valid_id=1 normally.
  - All three wrap modulo 2^CNT_W and clear only on clr.
- Undefined: no counter registers exist. The three counter outputs are tied to 0.

Test Plan:
- Reset: assert clr mid-cycle with valid data loaded -> all outputs 0 and bubble_ex=1 immediately, without a clock edge. Counters read 0.
- Normal pass-through: valid_id=1, pc_id=0x40, rd=5, regwr=1, aluctrl=3 -> next cycle pc_ex=0x40, rd_addr_ex=5, regwr_ex=1, valid_ex=1, bubble_ex=0. instr_cnt=1.
- Load-use stall: stall=1 for 2 cycles with ID holding pc 0x44 -> 2 bubble cycles (valid_ex=0, regwr_ex=0, rd_addr_ex=0). Third cycle pc_ex=0x44. stall_cnt=2.
- Flush plus stall together: flush=1, stall=1 -> bubble. flush_cnt +1, stall_cnt unchanged.
- Invalid ID slot: valid_id=0, regwr_id=1, memwr_id=1, rd=7 -> regwr_ex=0, memwr_ex=0, rd_addr_ex=0. bubble_ex=0 and instr_cnt unchanged.
- Counter wrap: CNT_W=4, 17 consecutive stall cycles -> stall_cnt=1. Without ID_EX_PERF_CNT_EN, all counters stay 0.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded instruction, operands and control from ID and presents them to EX.
// Latency: 1 cycle. Flush or stall loads a bubble. Optional hazard counters are enabled by define ID_EX_PERF_CNT_EN.
// Backpressure: none held here; stall never freezes this register, it only injects a bubble (ID/IF keep their own state).
module id_ex_stage_reg #(
    parameter int XLEN      = 32,
    parameter int ALUCTRL_W = 4,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 valid_id,
    input  logic [XLEN-1:0]      pc_id,
    input  logic [XLEN-1:0]      rs1_data_id,
    input  logic [XLEN-1:0]      rs2_data_id,
    input  logic [XLEN-1:0]      imm_id,
    input  logic [4:0]           rs1_addr_id,
    input  logic [4:0]           rs2_addr_id,
    input  logic [4:0]           rd_addr_id,
    input  logic                 regwr_id,
    input  logic                 mem2reg_id,
    input  logic                 memwr_id,
    input  logic                 branch_id,
    input  logic [ALUCTRL_W-1:0] aluctrl_id,
    output logic                 valid_ex,
    output logic [XLEN-1:0]      pc_ex,
    output logic [XLEN-1:0]      rs1_data_ex,
    output logic [XLEN-1:0]      rs2_data_ex,
    output logic [XLEN-1:0]      imm_ex,
    output logic [4:0]           rs1_addr_ex,
    output logic [4:0]           rs2_addr_ex,
    output logic [4:0]           rd_addr_ex,
    output logic                 regwr_ex,
    output logic                 mem2reg_ex,
    output logic                 memwr_ex,
    output logic                 branch_ex,
    output logic [ALUCTRL_W-1:0] aluctrl_ex,
    output logic                 bubble_ex,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt,
    output logic [CNT_W-1:0]     instr_cnt
);

    // Flush wins over stall; both simply turn the EX slot into a bubble.
    logic load_bubble;
    logic load_normal;

    assign load_bubble = flush | stall;
    assign load_normal = ~load_bubble;

    logic                 valid_q,    valid_d;
    logic [XLEN-1:0]      pc_q,       pc_d;
    logic [XLEN-1:0]      rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]      rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]      imm_q,      imm_d;
    logic [4:0]           rs1_addr_q, rs1_addr_d;
    logic [4:0]           rs2_addr_q, rs2_addr_d;
    logic [4:0]           rd_addr_q,  rd_addr_d;
    logic                 regwr_q,    regwr_d;
    logic                 mem2reg_q,  mem2reg_d;
    logic                 memwr_q,    memwr_d;
    logic                 branch_q,   branch_d;
    logic [ALUCTRL_W-1:0] aluctrl_q,  aluctrl_d;
    logic                 bubble_q,   bubble_d;

    // Next-state: bubble (all zero) on flush/stall, else ID copy with side-effecting fields gated by valid_id.
    always_comb begin
        valid_d    = 1'b0;
        pc_d       = '0;
        rs1_data_d = '0;
        rs2_data_d = '0;
        imm_d      = '0;
        rs1_addr_d = '0;
        rs2_addr_d = '0;
        rd_addr_d  = '0;
        regwr_d    = 1'b0;
        mem2reg_d  = 1'b0;
        memwr_d    = 1'b0;
        branch_d   = 1'b0;
        aluctrl_d  = '0;
        bubble_d   = 1'b1;
        if (load_normal) begin
            valid_d    = valid_id;
            pc_d       = pc_id;
            rs1_data_d = rs1_data_id;
            rs2_data_d = rs2_data_id;
            imm_d      = imm_id;
            rs1_addr_d = rs1_addr_id;
            rs2_addr_d = rs2_addr_id;
            // An empty ID slot must never write the register file or memory.
            rd_addr_d  = valid_id ? rd_addr_id : 5'd0;
            regwr_d    = regwr_id   & valid_id;
            mem2reg_d  = mem2reg_id & valid_id;
            memwr_d    = memwr_id   & valid_id;
            branch_d   = branch_id  & valid_id;
            aluctrl_d  = aluctrl_id;
            bubble_d   = 1'b0;
        end
    end

    // Pipeline register; reset leaves a bubble in EX.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_addr_q  <= '0;
            regwr_q    <= 1'b0;
            mem2reg_q  <= 1'b0;
            memwr_q    <= 1'b0;
            branch_q   <= 1'b0;
            aluctrl_q  <= '0;
            bubble_q   <= 1'b1;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rd_addr_q  <= rd_addr_d;
            regwr_q    <= regwr_d;
            mem2reg_q  <= mem2reg_d;
            memwr_q    <= memwr_d;
            branch_q   <= branch_d;
            aluctrl_q  <= aluctrl_d;
            bubble_q   <= bubble_d;
        end
    end

    assign valid_ex    = valid_q;
    assign pc_ex       = pc_q;
    assign rs1_data_ex = rs1_data_q;
    assign rs2_data_ex = rs2_data_q;
    assign imm_ex      = imm_q;
    assign rs1_addr_ex = rs1_addr_q;
    assign rs2_addr_ex = rs2_addr_q;
    assign rd_addr_ex  = rd_addr_q;
    assign regwr_ex    = regwr_q;
    assign mem2reg_ex  = mem2reg_q;
    assign memwr_ex    = memwr_q;
    assign branch_ex   = branch_q;
    assign aluctrl_ex  = aluctrl_q;
    assign bubble_ex   = bubble_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    // Counter increments: a coincident stall is attributed to the flush only; counters wrap freely.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (flush) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else if (stall) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else if (valid_id) begin
            instr_cnt_d = instr_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign instr_cnt = instr_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule
